// File: rtl/nv_ram_rws_64x32_fifo_ctl.sv
// ---------------------------------------------------------------------------
// nv_ram_rws_64x32_fifo_ctl
//
// Drives both ports of an external nv_ram_rws_64x32 and presents it as a
// 32-bit FIFO. Pushes are written straight into the RAM. Reads are issued
// ahead into a 2-entry output buffer. That buffer hides the RAM's one-cycle
// registered-address read latency, so the pop side can run at one item per
// cycle.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   wr_pvld/prdy/pd push interface (valid/ready)
//   rd_pvld/prdy/pd pop interface (valid/ready), rd_pd is the FIFO head
//   ram_wa/we/di    RAM write port
//   ram_ra/re       RAM read address/enable (RAM registers ra on re)
//   ram_dout        RAM read data, M[ra registered]
//   count           total occupancy (RAM + in-flight read + output buffer)
//   pwrbus_in       power bus, forwarded unchanged on pwrbus_ram_pd
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data stable until that transfer
// happens. Ready never depends on valid of the same interface.
// ---------------------------------------------------------------------------
module nv_ram_rws_64x32_fifo_ctl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 32,
    parameter int CW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    output logic [CW-1:0] count,
    input  logic [31:0]   pwrbus_in,
    output logic [31:0]   pwrbus_ram_pd
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   ram_cnt;   // written entries whose read is not yet issued
    logic          infl;      // read issued last cycle, ram_dout valid now
    logic [DW-1:0] obuf0;     // head of FIFO
    logic [DW-1:0] obuf1;     // second entry
    logic [1:0]    out_cnt;   // valid entries in obuf (0..2)

    logic          push;
    logic          pop;
    logic          issue;
    logic [2:0]    obuf_need; // obuf occupancy after this edge, before a new issue
    logic [1:0]    obuf_base; // obuf occupancy after this edge's pop

    // Write side
    assign wr_prdy = !rst && (ram_cnt != FULL_CNT);
    assign push    = wr_pvld && wr_prdy;
    assign ram_we  = push;
    assign ram_wa  = wptr;
    assign ram_di  = wr_pd;

    // Read side
    assign rd_pvld = (out_cnt != 2'd0);
    assign rd_pd   = obuf0;
    assign pop     = rd_pvld && rd_prdy;

    // A read may be issued only if its data will have an obuf slot when it
    // returns next cycle. Counting the pending capture and this cycle's pop
    // lets the read stream run without bubbles.
    assign obuf_need = 3'(out_cnt) + 3'(infl) - 3'(pop);
    assign issue     = !rst && (ram_cnt != '0) && (obuf_need < 3'd2);
    assign ram_re    = issue;
    assign ram_ra    = rptr;

    assign obuf_base = out_cnt - 2'(pop);

    assign count = CW'(ram_cnt) + CW'(infl) + CW'(out_cnt);

    assign pwrbus_ram_pd = pwrbus_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            infl    <= 1'b0;
            out_cnt <= 2'd0;
            obuf0   <= '0;
            obuf1   <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (issue) begin
                rptr <= rptr + 1'b1;
            end
            infl    <= issue;
            ram_cnt <= ram_cnt + (AW+1)'(push) - (AW+1)'(issue);
            out_cnt <= out_cnt - 2'(pop) + 2'(infl);

            if (pop && (out_cnt == 2'd2)) begin
                obuf0 <= obuf1;
            end
            // A capture never coincides with out_cnt==2, because the issue
            // rule keeps out_cnt+infl <= 2. So a capture cannot collide with
            // the shift above.
            if (infl) begin
                if (obuf_base == 2'd0) begin
                    obuf0 <= ram_dout;
                end else begin
                    obuf1 <= ram_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_nv_ram_rws_64x32_fifo_ctl.sv
// ---------------------------------------------------------------------------
// Testbench for nv_ram_rws_64x32_fifo_ctl.
// The bench contains a behavioural model of the external 64x32 RAM. That RAM
// registers its read address on re, and dout is M[registered ra].
// The reference model is an ordered queue of accepted pushes. The expected
// occupancy is the queue length. Expected RAM addresses are the running
// push and issue totals taken modulo the depth.
// ---------------------------------------------------------------------------
module tb_nv_ram_rws_64x32_fifo_ctl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int CW    = 7;

    logic          clk;
    logic          rst;
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic [AW-1:0] ram_wa;
    logic          ram_we;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic [DW-1:0] ram_dout;
    logic [CW-1:0] count;
    logic [31:0]   pwrbus_in;
    logic [31:0]   pwrbus_ram_pd;

    nv_ram_rws_64x32_fifo_ctl #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_dout(ram_dout),
        .count(count),
        .pwrbus_in(pwrbus_in), .pwrbus_ram_pd(pwrbus_ram_pd)
    );

    // ---------------- external RAM model ----------------
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra_d;

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_d <= ram_ra;
    end
    assign ram_dout = mem[ra_d];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];
    int push_total = 0;
    int issue_total = 0;
    int pop_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            push_total  = 0;
            issue_total = 0;
            pop_total   = 0;
        end else begin
            check("pwrbus", pwrbus_ram_pd, pwrbus_in);
            check("count", 32'(count), exp_q.size());
            check("obuf_bound", 32'((issue_total - pop_total) <= 2), 32'd1);
            if (rd_pvld && rd_prdy) begin
                if (exp_q.size() == 0) begin
                    check("pop_on_empty", 32'd1, 32'd0);
                end else begin
                    check("rd_pd", rd_pd, exp_q.pop_front());
                end
                pop_total++;
            end
            if (ram_re) begin
                check("ram_re_has_data", 32'(issue_total < push_total), 32'd1);
                check("ram_ra", 32'(ram_ra), issue_total % DEPTH);
                issue_total++;
            end
            if (wr_pvld && wr_prdy) begin
                check("ram_we", 32'(ram_we), 32'd1);
                check("ram_wa", 32'(ram_wa), push_total % DEPTH);
                check("ram_di", ram_di, wr_pd);
                exp_q.push_back(wr_pd);
                push_total++;
            end else begin
                check("ram_we_idle", 32'(ram_we), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic rr);
        @(posedge clk);
        #1;
        wr_pvld   = wv;
        wr_pd     = wd;
        rd_prdy   = rr;
        pwrbus_in = $urandom;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        #1;
        while ((exp_q.size() != 0 || rd_pvld) && cyc < 400) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check(name, 32'(cyc < 400), 32'd1);
        drive(1'b0, '0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int p0;
        int target;
        int cyc;

        rst       = 1'b1;
        wr_pvld   = 1'b0;
        wr_pd     = '0;
        rd_prdy   = 1'b0;
        pwrbus_in = 32'h0;

        // Reset then idle
        repeat (2) begin
            @(negedge clk);
            check("rst_wr_prdy", 32'(wr_prdy), 32'd0);
            check("rst_ram_we", 32'(ram_we), 32'd0);
            check("rst_ram_re", 32'(ram_re), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_wr_prdy", 32'(wr_prdy), 32'd1);
        check("idle_rd_pvld", 32'(rd_pvld), 32'd0);
        check("idle_rd_pd", rd_pd, 32'd0);
        check("idle_count", 32'(count), 32'd0);

        // Single push latency
        drive(1'b1, 32'hA5A5_0001, 1'b0);
        @(negedge clk);
        check("lat_ram_we", 32'(ram_we), 32'd1);
        check("lat_ram_wa", 32'(ram_wa), 32'd0);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("lat_ram_re", 32'(ram_re), 32'd1);
        check("lat_ram_ra", 32'(ram_ra), 32'd0);
        check("lat_pvld_k1", 32'(rd_pvld), 32'd0);
        @(negedge clk);
        check("lat_pvld_k2", 32'(rd_pvld), 32'd0);
        @(negedge clk);
        check("lat_pvld_k3", 32'(rd_pvld), 32'd1);
        check("lat_rd_pd", rd_pd, 32'hA5A5_0001);
        check("lat_count", 32'(count), 32'd1);
        drain("drain_lat");

        // Fill to full with the consumer stalled
        for (int i = 0; i < 70; i++) drive(1'b1, 32'(i), 1'b0);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("full_count", 32'(count), 32'd66);
        check("full_wr_prdy", 32'(wr_prdy), 32'd0);
        drive(1'b0, '0, 1'b1);
        n = 0;
        for (int c = 0; c < 66; c++) begin
            @(negedge clk);
            if (rd_pvld) n++;
            if (c == 1) check("full_wr_prdy_back", 32'(wr_prdy), 32'd1);
        end
        check("full_drain_no_bubble", n, 32'd66);
        @(negedge clk);
        check("full_drained", 32'(rd_pvld), 32'd0);
        drive(1'b0, '0, 1'b0);

        // Streaming, one push and one pop per cycle
        p0 = pop_total;
        for (int c = 0; c < 200; c++) drive(1'b1, 32'(5000 + c), 1'b1);
        drive(1'b0, '0, 1'b0);
        check("stream_pops", pop_total - p0, 32'd197);
        @(negedge clk);
        check("stream_count", 32'(count), 32'd3);
        drain("drain_stream");

        // Random traffic
        target = push_total + 5000;
        for (int c = 0; c < 40000 && push_total < target; c++) begin
            drive(1'(($urandom_range(0, 1))), $urandom, 1'(($urandom_range(0, 1))));
        end
        check("random_done", 32'(push_total >= target), 32'd1);
        drain("drain_random");

        // Reset with a read in flight
        for (int i = 0; i < 41; i++) drive(1'b1, 32'hC000_0000 + 32'(i), 1'b0);
        drive(1'b0, '0, 1'b1);
        @(posedge clk);
        #1;
        check("pre_rst_count", 32'(count), 32'd40);
        rst     = 1'b1;
        rd_prdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_rd_pvld", 32'(rd_pvld), 32'd0);
        check("mid_rst_rd_pd", rd_pd, 32'd0);
        check("mid_rst_wr_prdy", 32'(wr_prdy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 32'h1234_5678, 1'b0);
        drive(1'b0, '0, 1'b0);
        cyc = 0;
        @(negedge clk);
        while (!rd_pvld && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("post_rst_wait", 32'(cyc < 20), 32'd1);
        check("post_rst_rd_pd", rd_pd, 32'h1234_5678);
        check("post_rst_count", 32'(count), 32'd1);
        drain("drain_post_rst");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
